// File: rtl/calculator_core.sv
// calculator_core: debounced-button ALU with iterative 16x16 MUL and restoring DIV
module calculator_core #(
    parameter logic [31:0] DB_MAX = 32'd1_9999,
    parameter logic [4:0]  ITER   = 5'd16
) (
    input  logic        clk_g,
    input  logic        rst,
    input  logic        button,
    input  logic [15:0] sw_a,
    input  logic [15:0] sw_b,
    input  logic [2:0]  sw_op,
    output logic [31:0] cal_result,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_DONE} state_t;
    state_t state_q, state_d;
    logic        sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d, stable_dly_q, stable_dly_d;
    logic [31:0] db_cnt_q, db_cnt_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] acc_q, acc_d, result_q, result_d, alu_res, mul_step, div_step;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d, err_q, err_d;
    logic        start, db_hit, last_step, div_fit;
    logic [16:0] div_trial, div_rem;

    assign cal_result = result_q;
    assign busy       = busy_q;
    assign err        = err_q;

    // all state registers, cleared together by the synchronous reset
    always_ff @(posedge clk_g) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            db_cnt_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            db_cnt_q     <= db_cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    // synchronise the button, accept a new level only after it holds for DB_MAX cycles
    always_comb begin
        sync1_d      = button;
        sync2_d      = sync1_q;
        db_hit       = db_cnt_q == DB_MAX;
        db_cnt_d     = (sync2_q == stable_q || db_hit) ? '0 : db_cnt_q + 32'd1;
        stable_d     = (sync2_q != stable_q && db_hit) ? sync2_q : stable_q;
        stable_dly_d = stable_q;
        start        = stable_q & ~stable_dly_q;
    end

    // sequencing: single-cycle ops skip ITER, as does divide-by-zero
    always_comb begin
        state_d   = state_q;
        last_step = cnt_q == ITER - 5'd1;
        case (state_q)
            S_IDLE:  state_d = start ? S_EXEC : S_IDLE;
            S_EXEC:  state_d = (!op_q[2] || !op_q[1] || (op_q[0] && b_q == '0)) ? S_DONE : S_ITER;
            S_ITER:  state_d = last_step ? S_DONE : S_ITER;
            default: state_d = S_IDLE;
        endcase
    end

    // done marks the cycle in which the freshly written result is first visible
    always_comb begin
        done = state_q == S_DONE;
    end

    // single-cycle ALU results
    always_comb begin
        case (op_q)
            3'd0:    alu_res = {16'b0, a_q} + {16'b0, b_q};
            3'd1:    alu_res = {16'b0, a_q} - {16'b0, b_q};
            3'd2:    alu_res = {16'b0, a_q & b_q};
            3'd3:    alu_res = {16'b0, a_q | b_q};
            3'd4:    alu_res = {16'b0, a_q ^ b_q};
            default: alu_res = {16'b0, a_q} << b_q[4:0];
        endcase
    end

    // acc holds the MUL partial product, or {remainder, dividend/quotient} for DIV
    always_comb begin
        mul_step  = acc_q + (b_q[cnt_q[3:0]] ? ({16'b0, a_q} << cnt_q[3:0]) : 32'b0);
        div_trial = {acc_q[31:16], acc_q[15]};
        div_fit   = div_trial >= {1'b0, b_q};
        div_rem   = div_fit ? div_trial - {1'b0, b_q} : div_trial;
        div_step  = {div_rem[15:0], acc_q[14:0], div_fit};
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        busy_d    = busy_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: if (start) begin
                a_d    = sw_a;
                b_d    = sw_b;
                op_d   = sw_op;
                err_d  = 1'b0;
                busy_d = 1'b1;
            end
            S_EXEC: begin
                cnt_d = '0;
                if (!op_q[2] || !op_q[1]) result_d = alu_res;
                else if (!op_q[0]) acc_d = '0;
                else if (b_q == '0) begin
                    result_d = 32'hFFFF_FFFF;
                    err_d    = 1'b1;
                end else acc_d = {16'b0, a_q};
            end
            S_ITER: begin
                acc_d    = op_q[0] ? div_step : mul_step;
                cnt_d    = cnt_q + 5'd1;
                result_d = last_step ? acc_d : result_q;
            end
            default: busy_d = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_calculator_core.sv
// tb_calculator_core: vector table, corner sequences and random ops against an arithmetic model
module tb_calculator_core;
    logic        clk_g = 1'b0, rst = 1'b1, button = 1'b0;
    logic [15:0] sw_a = '0, sw_b = '0;
    logic [2:0]  sw_op = '0;
    logic [31:0] cal_result;
    logic        busy, done, err;
    int          checks = 0, errors = 0, n_done = 0, n_rise = 0;
    logic        busy_prev = 1'b0;

    typedef struct {
        logic [15:0] a, b;
        logic [2:0]  op;
        logic [31:0] exp;
        logic        e;
    } vec_t;
    vec_t vecs[14];

    calculator_core #(.DB_MAX(32'd4)) dut (
        .clk_g(clk_g), .rst(rst), .button(button), .sw_a(sw_a), .sw_b(sw_b), .sw_op(sw_op),
        .cal_result(cal_result), .busy(busy), .done(done), .err(err)
    );

    always #5 clk_g = ~clk_g;

    // event counters read only during quiet windows
    always @(negedge clk_g) begin
        if (done) n_done++;
        if (busy && !busy_prev) n_rise++;
        busy_prev = busy;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        logic [31:0] ea, eb;
        ea = {16'b0, a};
        eb = {16'b0, b};
        case (op)
            3'd0: return ea + eb;
            3'd1: return ea - eb;
            3'd2: return ea & eb;
            3'd3: return ea | eb;
            3'd4: return ea ^ eb;
            3'd5: return ea << (b % 32);
            3'd6: return ea * eb;
            default: return (b == 0) ? 32'hFFFF_FFFF : (((ea % eb) << 16) | (ea / eb));
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_g);
    endtask

    task automatic wait_busy(input string tag);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_g);
            got = busy;
        end
        if (!got) check({tag, " busy_rise"}, {31'b0, busy}, 32'd1);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                          input logic [31:0] exp, input logic eerr, input string tag);
        int nb, doff, nd;
        bit lng;
        logic [31:0] res;
        logic ev;
        sw_a = a; sw_b = b; sw_op = op; button = 1'b1;
        wait_busy(tag);
        button = 1'b0;
        sw_a = 16'($urandom); sw_b = 16'($urandom); sw_op = 3'($urandom);
        nb = 1; nd = 0; doff = -1; res = 'x; ev = 1'bx;
        for (int i = 1; i < 40 && busy; i++) begin
            @(negedge clk_g);
            if (done) begin
                nd++;
                doff = i;
                res = cal_result;
                ev = err;
            end
            if (busy) nb++;
        end
        lng = op >= 3'd6 && !(op == 3'd7 && b == 0);
        check({tag, " result"}, res, exp);
        check({tag, " err"}, {31'b0, ev}, {31'b0, eerr});
        check({tag, " done_offset"}, doff, lng ? 32'd17 : 32'd1);
        check({tag, " busy_cycles"}, nb, lng ? 32'd18 : 32'd2);
        check({tag, " done_count"}, nd, 32'd1);
        tick(10);
    endtask

    initial begin
        int r0, d0;
        logic [15:0] ra, rb;
        logic [2:0] rop;
        vecs[0]  = '{16'hFFFF, 16'h0001, 3'd0, 32'h0001_0000, 1'b0};
        vecs[1]  = '{16'h0001, 16'h0002, 3'd1, 32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{16'hF0F0, 16'h3C3C, 3'd2, 32'h0000_3030, 1'b0};
        vecs[3]  = '{16'hF0F0, 16'h3C3C, 3'd3, 32'h0000_FCFC, 1'b0};
        vecs[4]  = '{16'hF0F0, 16'h3C3C, 3'd4, 32'h0000_CCCC, 1'b0};
        vecs[5]  = '{16'hFFFF, 16'h0014, 3'd5, 32'hFFF0_0000, 1'b0};
        vecs[6]  = '{16'h1234, 16'h0021, 3'd5, 32'h0000_2468, 1'b0};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 3'd6, 32'hFFFE_0001, 1'b0};
        vecs[8]  = '{16'h0003, 16'h0005, 3'd6, 32'h0000_000F, 1'b0};
        vecs[9]  = '{16'd1000, 16'd7,    3'd7, 32'h0006_008E, 1'b0};
        vecs[10] = '{16'h0007, 16'h0009, 3'd7, 32'h0007_0000, 1'b0};
        vecs[11] = '{16'h1234, 16'h0000, 3'd7, 32'hFFFF_FFFF, 1'b1};
        vecs[12] = '{16'h0002, 16'h0003, 3'd0, 32'h0000_0005, 1'b0};
        vecs[13] = '{16'h0005, 16'h0003, 3'd1, 32'h0000_0002, 1'b0};

        tick(3);
        check("reset cal_result", cal_result, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        tick(3);

        // bouncing button: only the settled high level may start an op
        r0 = n_rise; d0 = n_done;
        sw_a = 16'd1; sw_b = 16'd1; sw_op = 3'd0;
        for (int i = 0; i < 10; i++) begin
            button = (i % 2 == 0);
            tick(2);
        end
        check("bounce no_start", n_rise - r0, 32'd0);
        button = 1'b1;
        tick(12);
        button = 1'b0;
        tick(30);
        check("bounce start_count", n_rise - r0, 32'd1);
        check("bounce done_count", n_done - d0, 32'd1);
        check("bounce result", cal_result, 32'd2);

        for (int i = 0; i < 14; i++) begin
            check($sformatf("vec%0d err_sticky", i), {31'b0, err}, {31'b0, (i == 0) ? 1'b0 : vecs[i-1].e});
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].e, $sformatf("vec%0d", i));
        end

        // a second press during a MUL is dropped
        r0 = n_rise; d0 = n_done;
        sw_a = 16'hFFFF; sw_b = 16'hFFFF; sw_op = 3'd6; button = 1'b1;
        wait_busy("mul_overlap");
        button = 1'b0;
        sw_a = 16'd1; sw_b = 16'd1; sw_op = 3'd0;
        tick(5);
        button = 1'b1;
        tick(10);
        button = 1'b0;
        tick(40);
        check("mul_overlap starts", n_rise - r0, 32'd1);
        check("mul_overlap done_count", n_done - d0, 32'd1);
        check("mul_overlap result", cal_result, 32'hFFFE_0001);

        // reset in the middle of a DIV aborts it silently
        sw_a = 16'd1000; sw_b = 16'd7; sw_op = 3'd7; button = 1'b1;
        wait_busy("div_reset");
        button = 1'b0;
        tick(9);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("div_reset cal_result", cal_result, 32'd0);
        check("div_reset busy", {31'b0, busy}, 32'd0);
        check("div_reset done", {31'b0, done}, 32'd0);
        d0 = n_done;
        tick(30);
        check("div_reset no_done", n_done - d0, 32'd0);
        run_op(16'd1000, 16'd7, 3'd7, 32'h0006_008E, 1'b0, "after_reset");

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            rop = 3'($urandom_range(0, 7));
            run_op(ra, rb, rop, model(ra, rb, rop), rop == 3'd7 && rb == 0, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
